// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: shared op/state encodings for the multiply/divide sequencer
package mdu_seq_pkg;
  localparam int MDU_OPW = 3;
  typedef enum logic [MDU_OPW-1:0] {MDU_MULT, MDU_DIV, MDU_MTHI, MDU_MTLO} mdu_op_t;
  typedef enum logic [2:0] {IDLE, MUL, DIV, DONE, HOLD} mdu_state_t;
endpackage

// File: rtl/mdu_seq_divider.sv
// mdu_divider: iterative restoring divider, one quotient bit per cycle, signed fixup on output
module mdu_divider
  import mdu_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              start,
  input  logic              sign,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quo,
  output logic [DATA_W-1:0] rem
);
  localparam int CW = $clog2(DATA_W);
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] q, r, d, a_raw;
  logic neg_q, neg_r, dz;
  logic [DATA_W:0] sh, diff;
  always_comb begin
    sh = {r, q[DATA_W-1]};
    diff = sh - {1'b0, d};
  end
  assign done = busy & (dz | cnt == CW'(DATA_W-1));
  assign quo = dz ? '1 : neg_q ? -q : q;
  assign rem = dz ? a_raw : neg_r ? -r : r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      q <= '0;
      r <= '0;
      d <= '0;
      a_raw <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
    end else if (clr) begin
      busy <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      q <= (sign & a[DATA_W-1]) ? -a : a;
      r <= '0;
      d <= (sign & b[DATA_W-1]) ? -b : b;
      a_raw <= a;
      neg_q <= sign & (a[DATA_W-1] ^ b[DATA_W-1]);
      neg_r <= sign & a[DATA_W-1];
      dz <= b == '0;
    end else if (busy) begin
      busy <= !done;
      cnt <= done ? '0 : cnt + 1'b1;
      q <= {q[DATA_W-2:0], !diff[DATA_W]};
      r <= diff[DATA_W] ? sh[DATA_W-1:0] : diff[DATA_W-1:0];
    end
  end
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: EX-stage multiply/divide sequencer owning HI/LO, with stall/flush handling
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_stall,
  input  logic              reg_flush,
  input  logic              req,
  input  mdu_op_t           op,
  input  logic              sign,
  input  logic [DATA_W-1:0] source_a,
  input  logic [DATA_W-1:0] source_b,
  output logic              alu_stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int CW = $clog2(MUL_LAT + 1);
  mdu_state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] opa, opb, quo, rem;
  logic sgn, mul_op, go_mul, go_div, mv, div_busy, div_done;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] pipe [MUL_LAT];
  always_comb begin
    go_mul = st == IDLE & req & op == MDU_MULT;
    go_div = st == IDLE & req & op == MDU_DIV;
    mv = st == IDLE & req & !reg_stall & !reg_flush;
    prod = {{DATA_W{sgn & opa[DATA_W-1]}}, opa} * {{DATA_W{sgn & opb[DATA_W-1]}}, opb};
    alu_stall = go_mul | go_div | st == MUL | (st == DIV & div_busy);
    nxt = st;
    if (reg_flush) nxt = IDLE;
    else
      case (st)
        IDLE: nxt = go_mul ? MUL : go_div ? DIV : IDLE;
        MUL: nxt = cnt == CW'(MUL_LAT - 1) ? DONE : MUL;
        DIV: nxt = div_done ? DONE : DIV;
        DONE, HOLD: nxt = reg_stall ? HOLD : IDLE;
        default: nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      opa <= '0;
      opb <= '0;
      sgn <= 1'b0;
      mul_op <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      st <= nxt;
      cnt <= (st == MUL & !reg_flush) ? cnt + 1'b1 : '0;
      if ((go_mul | go_div) & !reg_flush) begin
        opa <= source_a;
        opb <= source_b;
        sgn <= sign;
        mul_op <= go_mul;
      end
      if (st == DONE & !reg_flush) begin
        hi <= mul_op ? pipe[MUL_LAT-1][2*DATA_W-1:DATA_W] : rem;
        lo <= mul_op ? pipe[MUL_LAT-1][DATA_W-1:0] : quo;
      end
      if (mv & op == MDU_MTHI) hi <= source_a;
      if (mv & op == MDU_MTLO) lo <= source_a;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
    else begin
      pipe[0] <= prod;
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  mdu_divider #(.DATA_W(DATA_W)) u_div (
    .clk(clk),
    .rst(rst),
    .clr(reg_flush),
    .start(go_div & !reg_flush),
    .sign(sign),
    .a(source_a),
    .b(source_b),
    .busy(div_busy),
    .done(div_done),
    .quo(quo),
    .rem(rem)
  );
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: randomized and directed checks of mdu_seq against a transaction-level model
module tb_mdu_seq;
  import mdu_seq_pkg::*;
  localparam int W = 32, LAT = 2;
  logic clk = 0, rst = 1, reg_stall = 0, reg_flush = 0, req = 0, sign = 0;
  mdu_op_t op = MDU_MULT;
  logic [W-1:0] source_a = '0, source_b = '0;
  logic alu_stall;
  logic [W-1:0] hi, lo;
  int total = 0, bad = 0;
  int busy_left = 0;
  bit pend = 0, hold = 0;
  logic [W-1:0] rhi = '0, rlo = '0, mhi = '0, mlo = '0;
  mdu_seq #(.DATA_W(W), .MUL_LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .reg_stall(reg_stall),
    .reg_flush(reg_flush),
    .req(req),
    .op(op),
    .sign(sign),
    .source_a(source_a),
    .source_b(source_b),
    .alu_stall(alu_stall),
    .hi(hi),
    .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [2*W-1:0] mul_ref(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return 64'(x * y);
  endfunction
  function automatic logic [2*W-1:0] div_ref(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint x, y;
    if (b == 0) return {a, {W{1'b1}}};
    if (!s) return {a % b, a / b};
    x = longint'($signed(a));
    y = longint'($signed(b));
    return {32'(x % y), 32'(x / y)};
  endfunction
  function automatic logic m_idle();
    return busy_left == 0 && !pend && !hold;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_left = 0;
      pend = 0;
      hold = 0;
      mhi = '0;
      mlo = '0;
    end else if (reg_flush) begin
      busy_left = 0;
      pend = 0;
      hold = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      pend = busy_left == 0;
    end else if (pend) begin
      mhi = rhi;
      mlo = rlo;
      pend = 0;
      hold = reg_stall;
    end else if (hold) hold = reg_stall;
    else if (req) begin
      if (op == MDU_MULT) begin
        {rhi, rlo} = mul_ref(sign, source_a, source_b);
        busy_left = LAT;
      end else if (op == MDU_DIV) begin
        {rhi, rlo} = div_ref(sign, source_a, source_b);
        busy_left = source_b == 0 ? 1 : W;
      end else if (op == MDU_MTHI && !reg_stall) mhi = source_a;
      else if (op == MDU_MTLO && !reg_stall) mlo = source_a;
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      check("stall", W'(alu_stall), W'(busy_left > 0 || (m_idle() && req && (op == MDU_MULT || op == MDU_DIV))));
      check("hi", hi, mhi);
      check("lo", lo, mlo);
    end
  end
  task automatic issue(input mdu_op_t o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b, output int n);
    req = 1;
    op = o;
    sign = s;
    source_a = a;
    source_b = b;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!alu_stall) break;
      n++;
      @(posedge clk);
      #1;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got %0d stall cycles want <100", n);
    end
    @(posedge clk);
    #1;
    req = 0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int n;
    #12;
    check("rst_stall", W'(alu_stall), '0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    #10 rst = 0;
    @(posedge clk);
    #1;
    issue(MDU_MULT, 1, -32'sd3, 32'd5, n);
    check("mult_cycles", n, 3);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFF1);
    issue(MDU_DIV, 0, 32'd100, 32'd7, n);
    check("divu_cycles", n, 33);
    check("divu_lo", lo, 32'h0000000E);
    check("divu_hi", hi, 32'h00000002);
    issue(MDU_DIV, 1, -32'sd7, 32'd2, n);
    check("div_nn_lo", lo, 32'hFFFFFFFD);
    check("div_nn_hi", hi, 32'hFFFFFFFF);
    issue(MDU_DIV, 1, 32'd7, -32'sd2, n);
    check("div_pn_lo", lo, 32'hFFFFFFFD);
    check("div_pn_hi", hi, 32'h00000001);
    issue(MDU_DIV, 0, 32'h1234, 32'd0, n);
    check("dz_cycles", n, 2);
    check("dz_lo", lo, 32'hFFFFFFFF);
    check("dz_hi", hi, 32'h00001234);
    req = 1;
    op = MDU_DIV;
    sign = 0;
    source_a = 32'd1000;
    source_b = 32'd3;
    repeat (10) @(posedge clk);
    #1 reg_flush = 1;
    @(posedge clk);
    #1 reg_flush = 0;
    req = 0;
    @(negedge clk);
    check("flush_stall", W'(alu_stall), '0);
    check("flush_hi", hi, 32'h00001234);
    check("flush_lo", lo, 32'hFFFFFFFF);
    repeat (40) @(posedge clk);
    #1 check("flush_lo_late", lo, 32'hFFFFFFFF);
    req = 1;
    op = MDU_MULT;
    sign = 0;
    source_a = 32'd6;
    source_b = 32'd7;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (!alu_stall) break;
      n++;
      @(posedge clk);
      #1;
    end
    check("hold_cycles", n, 3);
    #1 reg_stall = 1;
    repeat (3) @(posedge clk);
    #1 reg_stall = 0;
    @(negedge clk);
    check("hold_stall", W'(alu_stall), '0);
    @(posedge clk);
    #1 req = 0;
    check("hold_lo", lo, 32'd42);
    check("hold_hi", hi, 32'd0);
    req = 1;
    op = MDU_MTHI;
    source_a = 32'hDEADBEEF;
    @(negedge clk);
    check("mthi_stall", W'(alu_stall), '0);
    @(posedge clk);
    #1 req = 0;
    check("mthi_hi", hi, 32'hDEADBEEF);
    check("mthi_lo", lo, 32'd42);
    req = 1;
    op = MDU_MULT;
    source_a = 32'd3;
    source_b = 32'd4;
    @(posedge clk);
    #1;
    #2 rst = 1;
    req = 0;
    #1;
    check("arst_stall", W'(alu_stall), '0);
    check("arst_hi", hi, '0);
    check("arst_lo", lo, '0);
    #3 rst = 0;
    repeat (5) @(posedge clk);
    #1 check("arst_hi_late", hi, '0);
    check("arst_lo_late", lo, '0);
    repeat (1500) begin
      req = $urandom_range(0, 2) != 0;
      op = mdu_op_t'($urandom_range(0, 3));
      sign = 1'($urandom);
      source_a = $urandom;
      case ($urandom_range(0, 3))
        0: source_b = '0;
        1: source_b = W'($urandom_range(1, 20));
        2: source_b = -W'($urandom_range(1, 20));
        default: source_b = $urandom;
      endcase
      reg_stall = $urandom_range(0, 7) == 0;
      reg_flush = $urandom_range(0, 40) == 0;
      @(posedge clk);
      #1;
    end
    req = 0;
    reg_stall = 0;
    reg_flush = 0;
    repeat (40) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
